// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V cache controller slice.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } cache_ctrl_state_e;

    localparam int CACHE_OFFSET_W = 3;
    localparam int CACHE_INDEX_W  = 8;

endpackage

// File: rtl/riscv_cache_tags.sv
// Tag/valid register file: combinational lookup, one write port, flush-all.
module riscv_cache_tags
    import riscv_pkg::*;
#(
    parameter int INDEX_WIDTH = CACHE_INDEX_W,
    parameter int TAG_WIDTH   = 53
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic [INDEX_WIDTH-1:0] i_lk_idx,
    input  logic [TAG_WIDTH-1:0]   i_lk_tag,
    output logic                   o_hit,
    input  logic                   i_we,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     r_valid;
    logic [TAG_WIDTH-1:0] r_tag [LINES];

    // Valid bits: cleared by reset or flush, set when a line is filled.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag storage needs no reset; a tag is only trusted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_hit = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);

endmodule

// File: rtl/riscv_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Optional feature: define RISCV_CACHE_STATS_EN to add load hit/miss counters.
module riscv_cache_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INDEX_WIDTH = CACHE_INDEX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_arr_read,
    output logic                  o_arr_write,
    output logic [ADDR_WIDTH-1:0] o_arr_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_arr_wr_addr,
    output logic [DATA_WIDTH-1:0] o_arr_wdata,
    input  logic [DATA_WIDTH-1:0] i_arr_data,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef RISCV_CACHE_STATS_EN
    ,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt
`endif
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - CACHE_OFFSET_W;

    cache_ctrl_state_e r_state, w_state_nxt;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                   w_accept;
    logic                   w_hit;
    logic                   w_flush;
    logic                   w_tag_we;
    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [TAG_W-1:0]       w_req_tag;
    logic [INDEX_WIDTH-1:0] w_lat_idx;
    logic [TAG_W-1:0]       w_lat_tag;
    logic                   w_unused_off;

    assign w_req_idx    = i_req_addr[INDEX_WIDTH+CACHE_OFFSET_W-1:CACHE_OFFSET_W];
    assign w_req_tag    = i_req_addr[ADDR_WIDTH-1:INDEX_WIDTH+CACHE_OFFSET_W];
    assign w_lat_idx    = r_addr[INDEX_WIDTH+CACHE_OFFSET_W-1:CACHE_OFFSET_W];
    assign w_lat_tag    = r_addr[ADDR_WIDTH-1:INDEX_WIDTH+CACHE_OFFSET_W];
    assign w_unused_off = ^i_req_addr[CACHE_OFFSET_W-1:0];

    assign o_req_ready = (r_state == IDLE) && !i_flush;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_flush     = (r_state == IDLE) && i_flush;

    // Memory port is driven straight from state and the latched request,
    // so a reset in MEM drops the request on the following cycle.
    assign o_mem_req   = (r_state == MEM);
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    riscv_cache_tags #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_W)
    ) u_tags (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (w_flush),
        .i_lk_idx (w_req_idx),
        .i_lk_tag (w_req_tag),
        .o_hit    (w_hit),
        .i_we     (w_tag_we),
        .i_wr_idx (w_lat_idx),
        .i_wr_tag (w_lat_tag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the accepted request and capture load data from memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
            if (r_state == MEM && i_mem_ack && !r_we) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    // Next state plus array strobes, tag write and core response.
    always_comb begin
        w_state_nxt   = r_state;
        o_arr_read    = 1'b0;
        o_arr_write   = 1'b0;
        o_arr_rd_addr = '0;
        o_arr_wr_addr = '0;
        o_arr_wdata   = '0;
        o_rsp_valid   = 1'b0;
        o_rsp_data    = '0;
        w_tag_we      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!i_req_we) begin
                        o_arr_read    = 1'b1;
                        o_arr_rd_addr = {{(ADDR_WIDTH-INDEX_WIDTH){1'b0}}, w_req_idx};
                        w_state_nxt   = w_hit ? HIT : MEM;
                    end else begin
                        // Store hit updates the line in place; a miss does not allocate.
                        if (w_hit) begin
                            o_arr_write   = 1'b1;
                            o_arr_wr_addr = {{(ADDR_WIDTH-INDEX_WIDTH){1'b0}}, w_req_idx};
                            o_arr_wdata   = i_req_wdata;
                        end
                        w_state_nxt = MEM;
                    end
                end
            end
            HIT: begin
                o_rsp_valid = 1'b1;
                o_rsp_data  = i_arr_data;
                w_state_nxt = IDLE;
            end
            MEM: begin
                if (i_mem_ack) begin
                    if (!r_we) begin
                        o_arr_write   = 1'b1;
                        o_arr_wr_addr = {{(ADDR_WIDTH-INDEX_WIDTH){1'b0}}, w_lat_idx};
                        o_arr_wdata   = i_mem_rdata;
                        w_tag_we      = 1'b1;
                    end
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_rsp_valid = 1'b1;
                o_rsp_data  = r_we ? '0 : r_rdata;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef RISCV_CACHE_STATS_EN
    // Saturating load hit/miss counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (w_accept && !i_req_we) begin
            if (w_hit) begin
                if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 32'd1;
            end else begin
                if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_cache_ctrl.sv
// Randomized self-checking bench for riscv_cache_ctrl with a line-level reference model.
module tb_riscv_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [63:0] i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_data;
    logic        o_arr_read;
    logic        o_arr_write;
    logic [63:0] o_arr_rd_addr;
    logic [63:0] o_arr_wr_addr;
    logic [63:0] o_arr_wdata;
    logic [63:0] i_arr_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [63:0] i_mem_rdata = '0;
`ifdef RISCV_CACHE_STATS_EN
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
`endif

    always #5 clk = ~clk;

    riscv_cache_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (i_flush),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_arr_read    (o_arr_read),
        .o_arr_write   (o_arr_write),
        .o_arr_rd_addr (o_arr_rd_addr),
        .o_arr_wr_addr (o_arr_wr_addr),
        .o_arr_wdata   (o_arr_wdata),
        .i_arr_data    (i_arr_data),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata)
`ifdef RISCV_CACHE_STATS_EN
        ,
        .o_hit_cnt     (o_hit_cnt),
        .o_miss_cnt    (o_miss_cnt)
`endif
    );

    // Data array: 256 words, read data one cycle after the strobe.
    logic [63:0] arr_mem [256];
    always @(posedge clk) begin
        if (o_arr_write) arr_mem[o_arr_wr_addr[7:0]] <= o_arr_wdata;
        if (o_arr_read)  i_arr_data <= arr_mem[o_arr_rd_addr[7:0]];
    end

    // Reference model: per-line valid/tag/data plus backing memory.
    bit          m_valid [256];
    logic [52:0] m_tag   [256];
    logic [63:0] m_data  [256];
    logic [63:0] mem_model [logic [63:0]];
    int unsigned m_hits = 0;
    int unsigned m_miss = 0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (!mem_model.exists(a)) mem_model[a] = {$urandom, $urandom};
        return mem_model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    // One core transaction; lat = cycles before memory acks (if memory is used).
    task automatic txn(input logic we, input logic [63:0] a, input logic [63:0] wd, input int lat);
        logic [7:0]  idx;
        logic [52:0] tg;
        logic        hit;
        logic [63:0] rd;
        idx = a[10:3];
        tg  = a[63:11];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = wd;
        #1;
        chk("req_ready", {63'b0, o_req_ready}, 64'd1);
        chk("arr_read", {63'b0, o_arr_read}, {63'b0, !we});
        if (!we) chk("arr_rd_addr", o_arr_rd_addr, {56'b0, idx});
        chk("arr_write_acc", {63'b0, o_arr_write}, {63'b0, we && hit});
        if (we && hit) begin
            chk("arr_wr_addr_st", o_arr_wr_addr, {56'b0, idx});
            chk("arr_wdata_st", o_arr_wdata, wd);
            m_data[idx] = wd;
        end
        if (!we) begin
            if (hit) m_hits++; else m_miss++;
        end
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        if (!we && hit) begin
            chk("hit_rsp_valid", {63'b0, o_rsp_valid}, 64'd1);
            chk("hit_rsp_data", o_rsp_data, m_data[idx]);
            chk("hit_no_mem", {63'b0, o_mem_req}, 64'd0);
        end else begin
            for (int k = 0; k <= lat; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #1;
                end
                chk("mem_req", {63'b0, o_mem_req}, 64'd1);
                chk("mem_we", {63'b0, o_mem_we}, {63'b0, we});
                chk("mem_addr", o_mem_addr, a);
                if (we) chk("mem_wdata", o_mem_wdata, wd);
                chk("rsp_early", {63'b0, o_rsp_valid}, 64'd0);
            end
            rd = we ? {$urandom, $urandom} : mem_val(a);
            i_mem_ack = 1'b1; i_mem_rdata = rd;
            #1;
            chk("arr_write_fill", {63'b0, o_arr_write}, {63'b0, !we});
            if (!we) begin
                chk("arr_wr_addr_fill", o_arr_wr_addr, {56'b0, idx});
                chk("arr_wdata_fill", o_arr_wdata, rd);
                m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = rd;
            end else begin
                mem_model[a] = wd;
            end
            @(negedge clk);
            i_mem_ack = 1'b0; i_mem_rdata = '0;
            #1;
            chk("done_rsp_valid", {63'b0, o_rsp_valid}, 64'd1);
            chk("done_rsp_data", o_rsp_data, we ? 64'd0 : rd);
            chk("mem_req_drop", {63'b0, o_mem_req}, 64'd0);
        end
        @(negedge clk);
        #1;
        chk("rsp_end", {63'b0, o_rsp_valid}, 64'd0);
    endtask

    task automatic flush();
        @(negedge clk);
        i_flush = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 64'h40;
        #1;
        chk("flush_ready", {63'b0, o_req_ready}, 64'd0);
        chk("flush_no_read", {63'b0, o_arr_read}, 64'd0);
        @(negedge clk);
        i_flush = 1'b0; i_req_valid = 1'b0;
        #1;
        chk("flush_no_rsp", {63'b0, o_rsp_valid}, 64'd0);
        chk("flush_no_mem", {63'b0, o_mem_req}, 64'd0);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        mem_model[64'h1000] = 64'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", {63'b0, o_req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'b0, o_rsp_valid}, 64'd0);
        chk("rst_rsp_data", o_rsp_data, 64'd0);
        chk("rst_mem_req", {63'b0, o_mem_req}, 64'd0);
        chk("rst_mem_addr", o_mem_addr, 64'd0);
        chk("rst_mem_we", {63'b0, o_mem_we}, 64'd0);
`ifdef RISCV_CACHE_STATS_EN
        chk("rst_hit_cnt", {32'b0, o_hit_cnt}, 64'd0);
        chk("rst_miss_cnt", {32'b0, o_miss_cnt}, 64'd0);
`endif

        // Directed sequence.
        txn(1'b0, 64'h1000, 64'h0, 2);           // miss, fill 0xDEAD
        txn(1'b0, 64'h1000, 64'h0, 0);           // hit 0xDEAD
        chk("t2_line_data", m_data[0], 64'hDEAD);
        txn(1'b1, 64'h1000, 64'hBEEF, 1);        // store hit, write-through
        txn(1'b0, 64'h1000, 64'h0, 0);           // hit 0xBEEF
        txn(1'b0, 64'h1800, 64'h0, 3);           // conflict miss
        txn(1'b0, 64'h1000, 64'h0, 0);           // misses again, memory holds 0xBEEF
        chk("t4_refill", m_data[0], 64'hBEEF);
        txn(1'b1, 64'h2008, 64'h1234, 0);        // store miss, no allocate
        txn(1'b0, 64'h1800, 64'h0, 1);           // refill 0x1800
        flush();
        txn(1'b0, 64'h1800, 64'h0, 0);           // miss after flush

        // Randomized traffic over a small address pool to force hits and conflicts.
        for (int n = 0; n < 200; n++) begin
            logic [63:0] a;
            logic [63:0] t;
            logic [63:0] ix;
            t  = 64'($urandom_range(1, 4));
            ix = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 255)) : 64'($urandom_range(0, 3));
            a  = (t << 11) | (ix << 3);
            if ($urandom_range(0, 19) == 0) flush();
            txn($urandom_range(0, 2) == 0, a, {$urandom, $urandom}, $urandom_range(0, 3));
        end
`ifdef RISCV_CACHE_STATS_EN
        chk("hit_cnt", {32'b0, o_hit_cnt}, {32'b0, m_hits});
        chk("miss_cnt", {32'b0, o_miss_cnt}, {32'b0, m_miss});
`endif

        // Reset while waiting on memory: request dropped, no response.
        flush();
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 64'h3000;
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        chk("mid_mem_req", {63'b0, o_mem_req}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mem_drop", {63'b0, o_mem_req}, 64'd0);
        chk("rst_no_rsp", {63'b0, o_rsp_valid}, 64'd0);
`ifdef RISCV_CACHE_STATS_EN
        chk("rst2_hit_cnt", {32'b0, o_hit_cnt}, 64'd0);
        chk("rst2_miss_cnt", {32'b0, o_miss_cnt}, 64'd0);
`endif
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        chk("post_rst_rsp", {63'b0, o_rsp_valid}, 64'd0);
        chk("post_rst_ready", {63'b0, o_req_ready}, 64'd1);
        txn(1'b0, 64'h1000, 64'h0, 1);           // lines invalid after reset -> miss

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
